// File: rtl/chu_debounce_pkg.sv
// Shared constants for the debounced GPI slot core: register map and
// the reset value of the sample period.
package chu_debounce_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_RAW    = 5'd0;
  localparam logic [ADDR_W-1:0] REG_DB     = 5'd1;
  localparam logic [ADDR_W-1:0] REG_RISE   = 5'd2;
  localparam logic [ADDR_W-1:0] REG_FALL   = 5'd3;
  localparam logic [ADDR_W-1:0] REG_PERIOD = 5'd4;

  // 1 ms at 100 MHz
  localparam int unsigned DEF_PERIOD = 100000;

endpackage

// File: rtl/chu_debounce_gpi_if.sv
// FPro MMIO slot bus as seen by one slot core.
//   cs, read, write : slot strobes
//   addr            : register address
//   wr_data         : write data
//   rd_data         : read data (driven by the slot)
interface chu_debounce_gpi_if;
  import chu_debounce_pkg::*;

  logic              cs;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/chu_debounce_gpi_debounce_bit.sv
// One debounced bit: counts consecutive prescaler ticks on which the
// synchronized input disagrees with the debounced level, and flips the
// level after N_STABLE of them. Any agreeing cycle restarts the count.
//   clk, reset : clock, synchronous active-high reset
//   tick       : prescaler sample strobe
//   in         : synchronized pin level
//   db         : debounced level
module debounce_bit #(
  parameter int unsigned N_STABLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic in,
  output logic db
);

  localparam int unsigned SMP_W = (N_STABLE < 1) ? 1 : $clog2(N_STABLE + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(N_STABLE - 1);

  logic [SMP_W-1:0] smp;

  // Mismatch counter and debounced flop
  always_ff @(posedge clk) begin
    if (reset) begin
      smp <= '0;
      db  <= 1'b0;
    end else if (in == db) begin
      smp <= '0;
    end else if (tick) begin
      if (smp == SMP_LAST) begin
        db  <= ~db;
        smp <= '0;
      end else begin
        smp <= smp + SMP_W'(1);
      end
    end
  end

endmodule

// File: rtl/chu_debounce_gpi.sv
// Debounced GPI slot core: synchronizes W raw pins, debounces them on a
// programmable sample tick, and latches rising/falling edge events that
// firmware clears by writing 1s.
//   clk, reset : clock, synchronous active-high reset
//   bus        : MMIO slot bus (slave side)
//   din        : raw asynchronous pin inputs
// Registers: 0 RAW (ro), 1 DB (ro), 2 RISE (w1c), 3 FALL (w1c),
//            4 PERIOD (rw), others read 0.
module chu_debounce_gpi #(
  parameter int unsigned W          = 8,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned DEF_PERIOD = chu_debounce_pkg::DEF_PERIOD,
  parameter int unsigned N_STABLE   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  chu_debounce_gpi_if.slave    bus,
  input  logic [W-1:0]         din
);

  import chu_debounce_pkg::*;

  logic [W-1:0]        sync1;
  logic [W-1:0]        sync;
  logic [W-1:0]        db;
  logic [W-1:0]        db_d;
  logic [W-1:0]        rise;
  logic [W-1:0]        fall;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_last_c;
  logic                tick_c;
  logic                wr_en_c;
  logic                period_we_c;
  logic [W-1:0]        rise_clr_c;
  logic [W-1:0]        fall_clr_c;

  // The read strobe has no side effects
  logic unused_read;
  assign unused_read = bus.read;

  assign wr_en_c     = bus.cs & bus.write;
  assign period_we_c = wr_en_c && (bus.addr == REG_PERIOD);
  assign rise_clr_c  = (wr_en_c && (bus.addr == REG_RISE)) ? bus.wr_data[W-1:0] : '0;
  assign fall_clr_c  = (wr_en_c && (bus.addr == REG_FALL)) ? bus.wr_data[W-1:0] : '0;

  // Two-flop synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= din;
      sync  <= sync1;
    end
  end

  // Period 0 behaves as period 1 so the tick fires every cycle
  assign period_last_c = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick_c        = (cnt == period_last_c);

  // Sample-period register and prescaler; a PERIOD write restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= PERIOD_W'(DEF_PERIOD);
      cnt    <= '0;
    end else begin
      if (period_we_c) begin
        period <= bus.wr_data[PERIOD_W-1:0];
      end
      if (period_we_c || tick_c) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

  // One debouncer per pin
  for (genvar i = 0; i < W; i++) begin : g_bit
    debounce_bit #(
      .N_STABLE(N_STABLE)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .tick (tick_c),
      .in   (sync[i]),
      .db   (db[i])
    );
  end

  // Sticky edge flags; a new edge outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      db_d <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      db_d <= db;
      rise <= (rise & ~rise_clr_c) | (db & ~db_d);
      fall <= (fall & ~fall_clr_c) | (~db & db_d);
    end
  end

  // Combinational read mux
  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      REG_RAW:    bus.rd_data = DATA_W'(sync);
      REG_DB:     bus.rd_data = DATA_W'(db);
      REG_RISE:   bus.rd_data = DATA_W'(rise);
      REG_FALL:   bus.rd_data = DATA_W'(fall);
      REG_PERIOD: bus.rd_data = DATA_W'(period);
      default:    bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_debounce_gpi.sv
// Bench for the debounced GPI slot core: table-driven register checks,
// hand-written latency/corner sequences, and randomized traffic compared
// against a tick-counting reference model.
module tb_chu_debounce_gpi;

  localparam int unsigned W   = 8;
  localparam int unsigned PW  = 24;
  localparam int unsigned DEF = 100000;
  localparam int unsigned NS  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;

  always #5 clk = ~clk;

  chu_debounce_gpi_if bus();

  chu_debounce_gpi #(
    .W(W), .PERIOD_W(PW), .DEF_PERIOD(DEF), .N_STABLE(NS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .din  (din)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: levels, edge flags, and per-bit count of ticks seen
  // during the current uninterrupted mismatch run.
  logic [W-1:0]  m_sync1, m_sync, m_db, m_rise, m_fall, m_pr, m_pf;
  logic [PW-1:0] m_period;
  int            m_phase;
  int            m_run [W];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    case (a)
      5'd0:    return 32'(m_sync);
      5'd1:    return 32'(m_db);
      5'd2:    return 32'(m_rise);
      5'd3:    return 32'(m_fall);
      5'd4:    return 32'(m_period);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic we, input logic [4:0] a,
                            input logic [31:0] wd, input logic [W-1:0] d);
    int           eff;
    logic         tick;
    logic [W-1:0] nd, clr_r, clr_f;
    if (rst) begin
      m_sync1 = '0; m_sync = '0; m_db = '0; m_rise = '0; m_fall = '0;
      m_pr = '0; m_pf = '0; m_period = PW'(DEF); m_phase = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      return;
    end
    eff  = (m_period == '0) ? 1 : int'(m_period);
    tick = ((m_phase % eff) == eff - 1);
    nd   = m_db;
    for (int i = 0; i < W; i++) begin
      if (m_sync[i] == m_db[i]) m_run[i] = 0;
      else if (tick) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == int'(NS)) begin
          nd[i] = ~m_db[i];
          m_run[i] = 0;
        end
      end
    end
    clr_r  = (we && a == 5'd2) ? wd[W-1:0] : '0;
    clr_f  = (we && a == 5'd3) ? wd[W-1:0] : '0;
    m_rise = (m_rise & ~clr_r) | m_pr;
    m_fall = (m_fall & ~clr_f) | m_pf;
    m_pr   = nd & ~m_db;
    m_pf   = ~nd & m_db;
    m_db   = nd;
    if (we && a == 5'd4) begin
      m_period = wd[PW-1:0];
      m_phase  = 0;
    end else begin
      m_phase = m_phase + 1;
    end
    m_sync = m_sync1;
    m_sync1 = d;
  endtask

  // One bus cycle: drive at negedge, sample read data, then advance the model
  task automatic step(input logic rst, input logic we, input logic [4:0] a,
                      input logic [31:0] wd, input logic [W-1:0] d,
                      output logic [31:0] rd);
    @(negedge clk);
    reset = rst; bus.cs = we; bus.write = we; bus.read = ~we;
    bus.addr = a; bus.wr_data = wd; din = d;
    #1;
    rd = bus.rd_data;
    check("model_rd", rd, model_rd(a));
    @(posedge clk);
    model_edge(rst, we, a, wd, d);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t         tbl [13];
  vec_t         rtbl[6];
  logic [31:0]  rd;
  logic [W-1:0] d;
  int           e;
  bit           found;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; din = '0;
    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.wr_data = '0;
    model_edge(1'b1, 1'b0, 5'd0, 32'd0, '0);
    step(1'b1, 1'b0, 5'd0, 0, '0, rd);
    step(1'b1, 1'b0, 5'd0, 0, '0, rd);

    // Reset values, register map, ignored writes
    tbl[0]  = '{1'b0, 5'd0,  32'd0,        32'd0};
    tbl[1]  = '{1'b0, 5'd1,  32'd0,        32'd0};
    tbl[2]  = '{1'b0, 5'd2,  32'd0,        32'd0};
    tbl[3]  = '{1'b0, 5'd3,  32'd0,        32'd0};
    tbl[4]  = '{1'b0, 5'd4,  32'd0,        32'(DEF)};
    tbl[5]  = '{1'b0, 5'd9,  32'd0,        32'd0};
    tbl[6]  = '{1'b0, 5'd31, 32'd0,        32'd0};
    tbl[7]  = '{1'b1, 5'd0,  32'hFF,       32'd0};
    tbl[8]  = '{1'b1, 5'd1,  32'hFF,       32'd0};
    tbl[9]  = '{1'b1, 5'd9,  32'hFFFF_FFFF, 32'd0};
    tbl[10] = '{1'b0, 5'd4,  32'd0,        32'(DEF)};
    tbl[11] = '{1'b1, 5'd4,  32'd4,        32'(DEF)};
    tbl[12] = '{1'b0, 5'd4,  32'd0,        32'd4};
    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].we, tbl[i].a, tbl[i].wd, '0, rd);
      check($sformatf("tbl%0d", i), rd, tbl[i].exp);
    end

    // Clean step on bit 0, period 4
    step(1'b0, 1'b0, 5'd1, 0, 8'h01, rd);
    found = 1'b0;
    for (e = 0; e < 40; e++) begin
      step(1'b0, 1'b0, 5'd1, 0, 8'h01, rd);
      if (rd[0]) begin found = 1'b1; break; end
    end
    check_range("step_latency", e + 1, 15, 18);
    step(1'b0, 1'b0, 5'd2, 0, 8'h01, rd);
    check("step_rise", rd, 32'h01);
    step(1'b0, 1'b1, 5'd2, 32'h01, 8'h01, rd);
    step(1'b0, 1'b0, 5'd2, 0, 8'h01, rd);
    check("rise_w1c", rd, 32'h00);

    // Glitch on bit 3 shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 5'd1, 0, 8'h09, rd);
      check("glitch_db_hi", rd, 32'h01);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0) ? 5'd1 : 5'd2, 0, 8'h01, rd);
      check("glitch_after", rd, (i % 2 == 0) ? 32'h01 : 32'h00);
    end

    // Bring bit 2 high, then fall with a clear on the set cycle
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 5'd1, 0, 8'h05, rd);
      if (rd[2]) begin found = 1'b1; break; end
    end
    check("bit2_up", 32'(found), 32'd1);
    step(1'b0, 1'b1, 5'd2, 32'h04, 8'h05, rd);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 5'd1, 0, 8'h01, rd);
      if (m_pf[2]) begin found = 1'b1; break; end
    end
    check("bit2_down", 32'(found), 32'd1);
    step(1'b0, 1'b1, 5'd3, 32'h04, 8'h01, rd);
    check("fall_pre", rd, 32'h00);
    step(1'b0, 1'b0, 5'd3, 0, 8'h01, rd);
    check("fall_set_wins", rd, 32'h04);
    step(1'b0, 1'b0, 5'd1, 0, 8'h01, rd);
    check("db_after_fall", rd, 32'h01);
    step(1'b0, 1'b1, 5'd3, 32'h04, 8'h01, rd);
    step(1'b0, 1'b0, 5'd3, 0, 8'h01, rd);
    check("fall_w1c", rd, 32'h00);

    // Period 0: tick every cycle
    step(1'b0, 1'b1, 5'd4, 32'd0, 8'h01, rd);
    step(1'b0, 1'b0, 5'd1, 0, 8'hA5, rd);
    for (e = 0; e < 40; e++) begin
      step(1'b0, 1'b0, 5'd1, 0, 8'hA5, rd);
      if (rd == 32'hA5) break;
    end
    check("p0_latency", 32'(e + 1), 32'd6);

    // Rewriting PERIOD mid-count restarts the prescaler phase
    step(1'b0, 1'b1, 5'd4, 32'd8, 8'hA5, rd);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd1, 0, 8'hA5, rd);
    step(1'b0, 1'b1, 5'd4, 32'd8, 8'h5A, rd);
    for (e = 0; e < 60; e++) begin
      step(1'b0, 1'b0, 5'd1, 0, 8'h5A, rd);
      if (rd == 32'h5A) break;
    end
    check("restart_latency", 32'(e), 32'd32);

    // Reset while counts are in progress
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd1, 0, 8'hA5, rd);
    step(1'b1, 1'b0, 5'd1, 0, 8'h00, rd);
    step(1'b1, 1'b0, 5'd1, 0, 8'h00, rd);
    rtbl[0] = '{1'b0, 5'd0, 32'd0, 32'd0};
    rtbl[1] = '{1'b0, 5'd1, 32'd0, 32'd0};
    rtbl[2] = '{1'b0, 5'd2, 32'd0, 32'd0};
    rtbl[3] = '{1'b0, 5'd3, 32'd0, 32'd0};
    rtbl[4] = '{1'b0, 5'd4, 32'd0, 32'(DEF)};
    rtbl[5] = '{1'b0, 5'd7, 32'd0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, rtbl[i].we, rtbl[i].a, rtbl[i].wd, '0, rd);
      check($sformatf("rst_mid%0d", i), rd, rtbl[i].exp);
    end

    // Randomized traffic against the model
    d = '0;
    step(1'b0, 1'b1, 5'd4, 32'($urandom_range(0, 3)), d, rd);
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 7) == 0) d = W'($urandom);
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        step(1'b1, 1'b0, 5'd0, 0, d, rd);
      end else if (r < 8) begin
        step(1'b0, 1'b1, 5'd4, 32'($urandom_range(0, 3)), d, rd);
      end else if (r < 70) begin
        step(1'b0, 1'b1, 5'($urandom_range(2, 3)), $urandom, d, rd);
      end else begin
        step(1'b0, 1'b0, 5'($urandom_range(0, 5)), 0, d, rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
